// File: rtl/seg_scan_decoder_pkg.sv
// seg_scan_decoder_pkg
//   Shared definitions for the multiplexed 7-segment scan decoder:
//   digit count, output widths, FSM state encoding and the
//   digit-to-segment pattern table (active-low, seg[0]=a .. seg[6]=g).
package seg_scan_decoder_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int COUNT_W    = 14;
  localparam int BCD_W      = 16;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_CONVERT = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  // Active-low segment pattern for a decimal digit; anything outside 0..9
  // returns all segments off.
  function automatic logic [6:0] digit_pat(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'h40;
      4'd1:    p = 7'h79;
      4'd2:    p = 7'h24;
      4'd3:    p = 7'h30;
      4'd4:    p = 7'h19;
      4'd5:    p = 7'h12;
      4'd6:    p = 7'h02;
      4'd7:    p = 7'h78;
      4'd8:    p = 7'h00;
      4'd9:    p = 7'h10;
      default: p = 7'h7F;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/seg_scan_decoder_decode.sv
// seg_pattern_decode
//   Combinational reverse lookup of an active-low 7-segment pattern.
//   Ports:
//     seg   in  [6:0]  active-low segment pattern
//     digit out [3:0]  decoded digit, 0 when the pattern is not recognised
//     bad   out        1 when the pattern matches no digit
module seg_pattern_decode
  import seg_scan_decoder_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] digit,
  output logic       bad
);

  always_comb begin
    digit = 4'd0;
    bad   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (seg == digit_pat(4'(i))) begin
        digit = 4'(i);
        bad   = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder
//   Monitors a 4-digit multiplexed, active-low 7-segment display driven from
//   the same clock, reassembles each scanned frame and converts it to binary.
//   Ports:
//     clk        in         system clock
//     reset      in         synchronous, active-high reset
//     seg        in  [6:0]  active-low segments, seg[0]=a .. seg[6]=g
//     an         in  [3:0]  active-low anodes, an[3]=thousands .. an[0]=units
//     count      out [13:0] binary value of the last good frame
//     bcd        out [15:0] BCD digits of the last good frame, [15:12]=thousands
//     valid      out        one-cycle pulse when a frame finishes decoding
//     frame_err  out        with valid: frame contained an undecodable pattern
//     blanked    out        all anodes off for at least BLANK_CYCLES
module seg_scan_decoder
  import seg_scan_decoder_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int BLANK_CYCLES  = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         seg,
  input  logic [3:0]         an,
  output logic [COUNT_W-1:0] count,
  output logic [BCD_W-1:0]   bcd,
  output logic               valid,
  output logic               frame_err,
  output logic               blanked
);

  localparam int STAB_W  = $clog2(STABLE_CYCLES + 1);
  localparam int BLANK_W = $clog2(BLANK_CYCLES + 1);
  localparam logic [STAB_W-1:0]  STAB_MAX  = STAB_W'(STABLE_CYCLES);
  localparam logic [BLANK_W-1:0] BLANK_MAX = BLANK_W'(BLANK_CYCLES);

  // ---------------------------------------------------------------------------
  // Stage p0: digit selection and stability qualification
  // ---------------------------------------------------------------------------
  logic [3:0]        w_an_act;
  logic              w_sel_onehot;
  logic [1:0]        w_sel_pos;
  logic              w_same;
  logic [STAB_W-1:0] w_stab_nxt;
  logic              w_capture;
  logic [3:0]        w_dec_digit;
  logic              w_dec_bad;

  logic [3:0]        r_an_p1;
  logic [6:0]        r_seg_p1;
  logic [STAB_W-1:0] r_stab_cnt;

  assign w_an_act     = ~an;
  assign w_sel_onehot = (w_an_act != 4'd0) && ((w_an_act & (w_an_act - 4'd1)) == 4'd0);
  assign w_same       = (an == r_an_p1) && (seg == r_seg_p1);

  always_comb begin
    case (an)
      4'b1110: w_sel_pos = 2'd0;
      4'b1101: w_sel_pos = 2'd1;
      4'b1011: w_sel_pos = 2'd2;
      4'b0111: w_sel_pos = 2'd3;
      default: w_sel_pos = 2'd0;
    endcase
  end

  // Counts how many consecutive cycles the current (an, seg) pair has been
  // present, saturating at STABLE_CYCLES. A non-one-hot anode value restarts it.
  always_comb begin
    w_stab_nxt = '0;
    if (w_sel_onehot) begin
      if (w_same)
        w_stab_nxt = (r_stab_cnt == STAB_MAX) ? STAB_MAX : r_stab_cnt + STAB_W'(1);
      else
        w_stab_nxt = STAB_W'(1);
    end
  end

  // Fire once on the cycle the count first reaches the threshold; staying
  // saturated on an unchanged selection does not re-capture.
  assign w_capture = w_sel_onehot && (w_stab_nxt == STAB_MAX) &&
                     !(w_same && (r_stab_cnt == STAB_MAX));

  always_ff @(posedge clk) begin
    r_an_p1  <= an;
    r_seg_p1 <= seg;
    if (reset) r_stab_cnt <= '0;
    else       r_stab_cnt <= w_stab_nxt;
  end

  seg_pattern_decode u_decode (
    .seg   (seg),
    .digit (w_dec_digit),
    .bad   (w_dec_bad)
  );

  // ---------------------------------------------------------------------------
  // Stage p1: per-position digit capture and frame assembly
  // ---------------------------------------------------------------------------
  logic [NUM_DIGITS-1:0][3:0] r_dig;
  logic [NUM_DIGITS-1:0]      r_bad;
  logic [NUM_DIGITS-1:0]      r_seen;
  logic [NUM_DIGITS-1:0]      w_seen_nxt;
  logic [NUM_DIGITS-1:0][3:0] r_snap_dig;
  logic [NUM_DIGITS-1:0]      r_snap_bad;
  logic                       w_accept;

  // A capture in the same cycle a frame is accepted belongs to the next frame.
  always_comb begin
    w_seen_nxt = w_accept ? '0 : r_seen;
    if (w_capture) w_seen_nxt[w_sel_pos] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (w_capture) r_dig[w_sel_pos] <= w_dec_digit;
    if (w_accept) begin
      r_snap_dig <= r_dig;
      r_snap_bad <= r_bad;
    end
    if (reset) begin
      r_seen <= '0;
      r_bad  <= '0;
    end else begin
      r_seen <= w_seen_nxt;
      if (w_capture) r_bad[w_sel_pos] <= w_dec_bad;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p2: frame FSM and serial binary conversion
  // ---------------------------------------------------------------------------
  state_t               r_state;
  state_t               w_state_nxt;
  logic [1:0]           r_conv_idx;
  logic [COUNT_W-1:0]   r_acc;
  logic [3:0]           w_conv_digit;
  logic [COUNT_W-1:0]   w_acc_nxt;
  logic                 w_conv_last;

  assign w_conv_digit = r_snap_dig[2'd3 - r_conv_idx];
  // acc*10 + digit; the largest result is 9999, so 14 bits never overflow.
  assign w_acc_nxt    = (r_acc << 3) + (r_acc << 1) +
                        {{(COUNT_W-4){1'b0}}, w_conv_digit};
  assign w_conv_last  = (r_state == ST_CONVERT) && (r_conv_idx == 2'd3);

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    valid       = 1'b0;
    frame_err   = 1'b0;
    case (r_state)
      ST_COLLECT: begin
        if (r_seen == '1) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        if (r_conv_idx == 2'd3) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        valid       = 1'b1;
        frame_err   = |r_snap_bad;
        w_state_nxt = ST_COLLECT;
      end
      default: w_state_nxt = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_COLLECT;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (w_accept)                    r_acc <= '0;
    else if (r_state == ST_CONVERT)  r_acc <= w_acc_nxt;

    if (reset)                       r_conv_idx <= 2'd0;
    else if (w_accept)               r_conv_idx <= 2'd0;
    else if (r_state == ST_CONVERT)  r_conv_idx <= r_conv_idx + 2'd1;
  end

  // Results are loaded on the edge entering DONE so they are already visible
  // while valid is high; a bad frame leaves the previous result in place.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      bcd   <= '0;
    end else if (w_conv_last && !(|r_snap_bad)) begin
      count <= w_acc_nxt;
      bcd   <= r_snap_dig;
    end
  end

  // ---------------------------------------------------------------------------
  // Blank detection
  // ---------------------------------------------------------------------------
  logic [BLANK_W-1:0] r_blank_cnt;

  always_ff @(posedge clk) begin
    if (reset)                    r_blank_cnt <= '0;
    else if (an != 4'b1111)       r_blank_cnt <= '0;
    else if (r_blank_cnt != BLANK_MAX)
                                  r_blank_cnt <= r_blank_cnt + BLANK_W'(1);
  end

  assign blanked = (r_blank_cnt == BLANK_MAX);

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder
//   Directed bench for seg_scan_decoder: scans hand-chosen frames onto the
//   anode/segment inputs and compares the decoded outputs with expected values.
module tb_seg_scan_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [13:0] count;
  logic [15:0] bcd;
  logic        valid;
  logic        frame_err;
  logic        blanked;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  seg_scan_decoder #(
    .STABLE_CYCLES (4),
    .BLANK_CYCLES  (1024)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .seg       (seg),
    .an        (an),
    .count     (count),
    .bcd       (bcd),
    .valid     (valid),
    .frame_err (frame_err),
    .blanked   (blanked)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] pat(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Called just after a rising edge; holds the selection for dwell edges and
  // returns just after the last of them.
  task automatic drive_digit(input int pos, input logic [6:0] p, input int dwell);
    an      = 4'b1111;
    an[pos] = 1'b0;
    seg     = p;
    repeat (dwell) @(posedge clk);
    #1;
  endtask

  task automatic scan_frame(input logic [6:0] p3, input logic [6:0] p2,
                            input logic [6:0] p1, input logic [6:0] p0,
                            input int dwell);
    @(posedge clk);
    #1;
    drive_digit(3, p3, dwell);
    drive_digit(2, p2, dwell);
    drive_digit(1, p1, dwell);
    drive_digit(0, p0, dwell);
    an  = 4'b1111;
    seg = 7'h7F;
  endtask

  // Waits (bounded) for the valid pulse; latency counts falling edges from
  // the end of the scan, 6 meaning valid 5 cycles after completion.
  task automatic expect_frame(input string tag, input logic [13:0] e_count,
                              input logic [15:0] e_bcd, input logic e_err,
                              input int e_lat);
    int lat;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (valid) begin
        lat = i;
        break;
      end
    end
    chk({tag, "_valid_seen"}, 32'(lat != 0), 32'd1);
    if (lat != 0) begin
      chk({tag, "_latency"}, 32'(lat), 32'(e_lat));
      chk({tag, "_count"}, 32'(count), 32'(e_count));
      chk({tag, "_bcd"}, 32'(bcd), 32'(e_bcd));
      chk({tag, "_frame_err"}, 32'(frame_err), 32'(e_err));
      @(negedge clk);
      chk({tag, "_pulse_width"}, 32'(valid), 32'd0);
    end
  endtask

  task automatic expect_none(input string tag, input int cycles);
    int nv;
    nv = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (valid) nv++;
    end
    chk(tag, 32'(nv), 32'd0);
  endtask

  initial begin
    int blank_at;

    reset = 1'b1;
    an    = 4'b1111;
    seg   = 7'h7F;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_bcd", 32'(bcd), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_blanked", 32'(blanked), 32'd0);

    scan_frame(pat(0), pat(1), pat(2), pat(3), 4);
    expect_frame("f0123", 14'd123, 16'h0123, 1'b0, 6);

    scan_frame(pat(9), pat(9), pat(9), pat(9), 4);
    expect_frame("f9999", 14'd9999, 16'h9999, 1'b0, 6);

    scan_frame(pat(0), pat(0), pat(0), pat(5), 4);
    expect_frame("f0005", 14'd5, 16'h0005, 1'b0, 6);

    // Undecodable pattern on an[1]: flagged, previous result held.
    scan_frame(pat(1), pat(2), 7'h7F, pat(4), 4);
    expect_frame("fbad", 14'd5, 16'h0005, 1'b1, 6);

    // Three-cycle dwell is one short of the threshold.
    scan_frame(pat(1), pat(2), pat(3), pat(4), 3);
    expect_none("short_dwell_no_valid", 20);
    chk("short_dwell_count", 32'(count), 32'd5);

    scan_frame(pat(1), pat(2), pat(3), pat(4), 4);
    expect_frame("f1234", 14'd1234, 16'h1234, 1'b0, 6);

    // Frame spanning a blank period: three digits, blank, then the units digit.
    @(posedge clk);
    #1;
    drive_digit(3, pat(4), 4);
    drive_digit(2, pat(5), 4);
    drive_digit(1, pat(6), 4);
    an  = 4'b0011;
    seg = 7'h7F;
    @(posedge clk);
    #1;
    an = 4'b1111;
    blank_at = 0;
    for (int i = 1; i <= 1100; i++) begin
      @(negedge clk);
      if (blanked) begin
        blank_at = i;
        break;
      end
    end
    chk("blank_cycle", 32'(blank_at), 32'd1025);
    @(posedge clk);
    #1;
    an  = 4'b1110;
    seg = pat(7);
    @(negedge clk);
    chk("blank_still_set", 32'(blanked), 32'd1);
    @(negedge clk);
    chk("blank_exit", 32'(blanked), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    an  = 4'b1111;
    seg = 7'h7F;
    expect_frame("fspan", 14'd4567, 16'h4567, 1'b0, 6);

    // Reset in the second CONVERT cycle aborts the frame.
    scan_frame(pat(1), pat(1), pat(1), pat(1), 4);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    expect_none("rst_abort_no_valid", 20);
    chk("rst_abort_count", 32'(count), 32'd0);
    chk("rst_abort_bcd", 32'(bcd), 32'd0);

    scan_frame(pat(8), pat(0), pat(4), pat(2), 4);
    expect_frame("f8042", 14'd8042, 16'h8042, 1'b0, 6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
